// File: rtl/sparq_cmd_dispatcher_pkg.sv
// rtl/sparq_cmd_dispatcher_pkg.sv - shared constants and types for the SPARQ command dispatcher
package sparq_cmd_dispatcher_pkg;

  localparam int FSIZE         = 32;
  localparam int COMMAND_WIDTH = 8;
  localparam int STATE_WIDTH   = 2;
  localparam int CMD_BASE      = 2;
  localparam int CMD_PHASES    = 3;
  localparam int ARG_WORDS     = 6;

  localparam logic [STATE_WIDTH-1:0] STATE_IDLE    = 2'd0;
  localparam logic [STATE_WIDTH-1:0] STATE_WORKING = 2'd1;

  typedef struct packed {
    logic                     valid;
    logic [COMMAND_WIDTH-1:0] command;
    logic [FSIZE-1:0]         data0;
    logic [FSIZE-1:0]         data1;
  } CommandDataPort;

  typedef logic [ARG_WORDS-1:0][FSIZE-1:0] DispatchArgs;

  typedef struct packed {
    logic       pending;
    logic       busy;
    logic [1:0] expect_ph;
  } ChanStatus;

endpackage

// File: rtl/sparq_cmd_dispatcher_if.sv
// rtl/sparq_cmd_dispatcher_if.sv - host command stream into the dispatcher
interface sparq_cmd_dispatcher_if;
  import sparq_cmd_dispatcher_pkg::*;

  CommandDataPort cmd_in;
  logic           cmd_ready;

  modport master (output cmd_in, input cmd_ready);
  modport slave  (input cmd_in, output cmd_ready);
endinterface

// File: rtl/sparq_cmd_channel.sv
// rtl/sparq_cmd_channel.sv - one engine channel: phase assembly, pending/busy job tracking
// Optional busy-cycle counter built when SPARQ_DISPATCH_PERF_EN is defined.
module sparq_cmd_channel
  import sparq_cmd_dispatcher_pkg::*;
#(
  parameter bit SINGLE = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr,
  input  logic [1:0]             phase,
  input  logic [FSIZE-1:0]       data0,
  input  logic [FSIZE-1:0]       data1,
  input  logic                   ch_ready,
  input  logic                   ch_done,
  output logic                   ch_valid,
  output DispatchArgs            args,
  output logic [STATE_WIDTH-1:0] state,
  output logic                   pending,
  output logic                   phase_err,
  output logic [31:0]            busy_cycles
);

  localparam logic [1:0] LAST = 2'(CMD_PHASES - 1);

  ChanStatus   st_q;
  DispatchArgs asm_q, asm_n, args_q;
  logic [1:0]  exp_n;
  logic        complete;
  logic        handshake;

  always_comb begin
    asm_n     = asm_q;
    exp_n     = st_q.expect_ph;
    complete  = 1'b0;
    phase_err = 1'b0;
    if (wr) begin
      if (SINGLE) begin
        asm_n              = '0;
        asm_n[{LAST, 1'b0}] = data0;
        asm_n[{LAST, 1'b1}] = data1;
        complete           = 1'b1;
      end else if (phase == 2'd0) begin
        // a fresh phase 0 always restarts the group, flagging any abandoned one
        phase_err = (st_q.expect_ph != 2'd0);
        asm_n[0]  = data0;
        asm_n[1]  = data1;
        exp_n     = 2'd1;
      end else if (phase == st_q.expect_ph) begin
        asm_n[{phase, 1'b0}] = data0;
        asm_n[{phase, 1'b1}] = data1;
        if (phase == LAST) begin
          complete = 1'b1;
          exp_n    = 2'd0;
        end else begin
          exp_n = phase + 2'd1;
        end
      end else begin
        phase_err = 1'b1;
        exp_n     = 2'd0;
      end
    end
  end

  assign ch_valid  = st_q.pending & ~st_q.busy;
  assign handshake = ch_valid & ch_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q   <= '0;
      asm_q  <= '0;
      args_q <= '0;
    end else begin
      asm_q          <= asm_n;
      st_q.expect_ph <= exp_n;
      // cmd_ready guarantees no completion lands while a block is still pending
      if (complete) begin
        args_q       <= asm_n;
        st_q.pending <= 1'b1;
      end else if (handshake) begin
        st_q.pending <= 1'b0;
      end
      if (handshake) begin
        st_q.busy <= 1'b1;
      end else if (ch_done) begin
        st_q.busy <= 1'b0;
      end
    end
  end

  assign args    = args_q;
  assign pending = st_q.pending;
  assign state   = (st_q.pending | st_q.busy) ? STATE_WORKING : STATE_IDLE;

`ifdef SPARQ_DISPATCH_PERF_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (st_q.busy && cnt_q != '1) begin
      cnt_q <= cnt_q + 32'd1;
    end
  end

  assign busy_cycles = cnt_q;
`else
  assign busy_cycles = '0;
`endif

endmodule

// File: rtl/sparq_cmd_dispatcher.sv
// rtl/sparq_cmd_dispatcher.sv - decodes host commands and dispatches argument blocks per engine channel
// Busy-cycle counters are built only when SPARQ_DISPATCH_PERF_EN is defined.
module sparq_cmd_dispatcher
  import sparq_cmd_dispatcher_pkg::*;
#(
  parameter int NUM_CH     = 7,
  parameter int CMD_BASE   = sparq_cmd_dispatcher_pkg::CMD_BASE,
  parameter int CMD_PHASES = sparq_cmd_dispatcher_pkg::CMD_PHASES,
  parameter int ARG_WORDS  = sparq_cmd_dispatcher_pkg::ARG_WORDS
) (
  input  logic                                     clk,
  input  logic                                     rst,
  sparq_cmd_dispatcher_if.slave                    cmd,
  output logic [NUM_CH-1:0]                        ch_valid,
  input  logic [NUM_CH-1:0]                        ch_ready,
  output logic [NUM_CH-1:0][ARG_WORDS-1:0][FSIZE-1:0] ch_args,
  input  logic [NUM_CH-1:0]                        ch_done,
  output logic [NUM_CH-1:0][STATE_WIDTH-1:0]       ch_state,
  output logic                                     err,
  input  logic                                     err_clr,
  output logic [NUM_CH-1:0][31:0]                  busy_cycles
);

  localparam logic [1:0] LAST = 2'(CMD_PHASES - 1);

  logic [NUM_CH-1:0] sel, pending, phase_err;
  logic [1:0]        phase;
  logic              legal, ready, accept, err_set;

  always_comb begin
    sel   = '0;
    phase = 2'd0;
    legal = 1'b0;
    if (int'(cmd.cmd_in.command) == 1) begin
      sel[0] = 1'b1;
      phase  = LAST;
      legal  = 1'b1;
    end
    for (int i = 1; i < NUM_CH; i++) begin
      for (int k = 0; k < CMD_PHASES; k++) begin
        if (int'(cmd.cmd_in.command) == CMD_BASE + (i - 1) * CMD_PHASES + k) begin
          sel[i] = 1'b1;
          phase  = 2'(k);
          legal  = 1'b1;
        end
      end
    end
  end

  // registered pending: stays conservative even if the slot drains this cycle
  assign ready         = !((phase == LAST) && |(sel & pending));
  assign cmd.cmd_ready = ready;
  assign accept        = cmd.cmd_in.valid & ready;
  assign err_set       = (accept & ~legal) | (|phase_err);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err <= 1'b0;
    end else if (err_set) begin
      err <= 1'b1;
    end else if (err_clr) begin
      err <= 1'b0;
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    sparq_cmd_channel #(
      .SINGLE (g == 0)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .wr          (accept & sel[g]),
      .phase       (phase),
      .data0       (cmd.cmd_in.data0),
      .data1       (cmd.cmd_in.data1),
      .ch_ready    (ch_ready[g]),
      .ch_done     (ch_done[g]),
      .ch_valid    (ch_valid[g]),
      .args        (ch_args[g]),
      .state       (ch_state[g]),
      .pending     (pending[g]),
      .phase_err   (phase_err[g]),
      .busy_cycles (busy_cycles[g])
    );
  end

endmodule

// File: doc/sparq_cmd_dispatcher.md
# sparq_cmd_dispatcher

Parametrised command front end for the SPARQ accelerator. Accepts the host's `CommandDataPort` stream and assembles the three-phase command groups (`*0`/`*1`/`*2`) into one 6-word argument block per engine channel. Dispatches each block to its engine over a valid/ready handshake with at most one outstanding job per channel, and tracks per-channel IDLE/WORKING state for the status port. It sits between the AXI-Lite command registers and the GEMM/AXI engines, and scales to any channel count.

## Interface
Parameters:
- `NUM_CH`, 7, engine channels. Ch0 = PE_RESET (single-phase); ch k≥1 = three-phase group k.
- `CMD_BASE`, 2, first three-phase command code.
- `CMD_PHASES`, 3, phases per grouped command.
- `ARG_WORDS`, 6, `FSIZE` words per argument block (2 per phase).

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `cmd_in`  in  `CommandDataPort`  valid, command[`COMMAND_WIDTH`], data0, data1.
- `cmd_ready`  out  1  command accepted when `cmd_in.valid & cmd_ready`.
- `ch_valid`  out  `NUM_CH`  argument block offered to channel.
- `ch_ready`  in  `NUM_CH`  engine takes block.
- `ch_args`  out  `NUM_CH`×`ARG_WORDS`×`FSIZE`  argument blocks. Word 2p = phase p data0; word 2p+1 = phase p data1.
- `ch_done`  in  `NUM_CH`  one-cycle engine completion pulse.
- `ch_state`  out  `NUM_CH`×`STATE_WIDTH`  `STATE_IDLE`/`STATE_WORKING`.
- `err`  out  1  sticky protocol error.
- `err_clr`  in  1  clears `err`.
- `busy_cycles`  out  `NUM_CH`×32  per-channel busy counters (see Configuration).

## Operation
- Decode:
  - code 1 → ch0, phase 2 (completes immediately; data0/data1 land in words 4/5, other words 0).
  - code c in [`CMD_BASE`, `CMD_BASE`+3(`NUM_CH`−1)−1] → ch = (c−`CMD_BASE`)/3+1, phase = (c−`CMD_BASE`)%3.
  - Any other code is illegal.
- Per channel:
  - Assembly register plus 2-bit expected-phase counter.
  - `pending` flag and `busy` flag.
- Phase rules for an accepted command on ch:
  - phase 0: store words 0/1, expect 1. If the channel was mid-assembly (expect≠0), set `err` and restart.
  - phase == expect (1 or 2): store words, expect+1.
  - phase 2 completes the group: copy the assembly to the `ch_args` slot, set `pending`, expect←0.
  - phase ≠ expect and ≠0: drop the command, set `err`, expect←0.
  - Illegal code: accepted (`cmd_ready`=1), dropped, `err` set.
- `cmd_ready`:
  - Combinational: 0 only when `cmd_in` decodes to a completing phase for a channel whose `pending`=1.
  - Uses the registered `pending`, so it is conservative even if that slot drains the same cycle.
- Dispatch:
  - `ch_valid[i] = pending[i] & ~busy[i]`.
  - Handshake clears `pending` and sets `busy`.
  - `ch_args[i]` is held stable while `pending`.
- Completion: `ch_done[i]` clears `busy[i]`. `ch_done` while not busy is ignored.
- `ch_state[i]` = WORKING if `pending|busy`, else IDLE.
- `err`: set has priority over `err_clr` in the same cycle.

## Timing
- Reset: all flags 0; expect=0; `ch_args`=0; `ch_valid`=0; `ch_state`=IDLE; `err`=0; `busy_cycles`=0. `cmd_ready`=1.
- Phase 2 accepted at cycle t → `pending` and `ch_valid` at t+1 (if not busy).
- Handshake at t → `busy` at t+1.
- `ch_done` at t → `busy`=0 at t+1; a queued block raises `ch_valid` at t+1.
- Throughput per channel: one new block can complete assembly while the previous job runs. A second completing phase stalls until dispatch.
- Channels are fully independent; simultaneous events on different channels never interact.
- Reset mid-operation discards all pending blocks and partial assemblies.

## Configuration
- `SPARQ_DISPATCH_PERF_EN`:
  - Defined: `busy_cycles[i]` increments each cycle `busy[i]`=1, saturating at 2³²−1, cleared by `rst` only.
  - Undefined: counters are not built; `busy_cycles` is tied to 0.

## Structure
- Shared package additions:
  - `CMD_BASE`, `CMD_PHASES`, `ARG_WORDS`.
  - Typedef `DispatchArgs` (packed array of `ARG_WORDS`×`FSIZE`).
  - Typedef `ChanStatus` (`pending`, `busy`, expect phase).
- Sub-module `sparq_cmd_channel`: one channel's assembly, phase check, pending/busy, and optional counter. Instantiated `NUM_CH` times in a generate loop. The top level holds decode, `cmd_ready`, and `err`.

## Test plan
- Codes 5,6,7 with data (1,2),(3,4),(5,6), `ch_ready`=1 → ch2 `ch_valid` one cycle after code 7; `ch_args`={1..6}; `ch_state[2]`=WORKING until `ch_done`.
- Code 1 data (0xA,0xB) → ch0 `ch_valid` next cycle; words 4/5 = 0xA/0xB, others 0.
- Codes 11,13 (phase skipped) → 13 dropped, `err`=1, no `ch_valid[4]`. `err_clr` → `err`=0. Then 11,12,13 dispatches normally.
- Ch1 busy (`ch_ready`=1, no done), send 2,3,4 twice → second group pending; the third code 4 sees `cmd_ready`=0. `ch_done[1]` → second block dispatched next cycle.
- Code 0 and code 20 with `NUM_CH`=7 → accepted, dropped, `err`=1, all `ch_valid`=0.
- With `SPARQ_DISPATCH_PERF_EN`, ch3 busy 10 cycles → `busy_cycles[3]`=10. Assert `rst` mid-job → all outputs return to reset values.
